// File: rtl/jtag_shift_engine_if.sv
// Command/response bundle between the host register block and jtag_shift_engine.
// The host drives commands through the master modport; the engine uses the slave modport.
`timescale 1ns/1ps
interface jtag_shift_engine_if #(
  parameter int MAX_BITS = 32
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [3:0]          cmd_sel;
  logic [5:0]          cmd_len;
  logic [MAX_BITS-1:0] cmd_tms;
  logic [MAX_BITS-1:0] cmd_tdi;
  logic                rsp_valid;
  logic [MAX_BITS-1:0] rsp_tdo;
  logic                busy;

  modport master (
    output cmd_valid, cmd_sel, cmd_len, cmd_tms, cmd_tdi,
    input  cmd_ready, rsp_valid, rsp_tdo, busy
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_len, cmd_tms, cmd_tdi,
    output cmd_ready, rsp_valid, rsp_tdo, busy
  );
endinterface

// File: rtl/jtag_shift_engine.sv
// jtag_shift_engine: bit-level JTAG master for the 12-way target mux.
// Accepts one shift command, toggles V_TCK with a half-period of CLK_DIV clocks,
// drives V_TMS/V_TDI while TCK is low, captures V_TDO and returns the vector.
// Optional build macro: JTAG_SAMPLE_LATE_EN -- sample TDO on the last clock of the
// TCK-high phase instead of on the clock edge that raises TCK.
`timescale 1ns/1ps
module jtag_shift_engine #(
  parameter int CLK_DIV  = 4,
  parameter int MAX_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  jtag_shift_engine_if.slave   bus,
  output logic [3:0]           jtag_sel,
  output logic                 v_tck,
  output logic                 v_tms,
  output logic                 v_tdi,
  input  logic                 v_tdo
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int              IDX_W    = $clog2(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [5:0]      LEN_MAX  = 6'(MAX_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [5:0]          bit_reg, bit_next;
  logic [5:0]          len_reg, len_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [MAX_BITS-1:0] tms_reg, tms_next;
  logic [MAX_BITS-1:0] tdi_reg, tdi_next;
  logic [MAX_BITS-1:0] cap_reg, cap_next;
  logic [3:0]          sel_next;

  logic                ready_reg;
  logic                busy_reg;
  logic                rsp_valid_reg;
  logic [MAX_BITS-1:0] rsp_tdo_reg;

  logic [5:0]          len_sat;
  logic                sample_now;
  logic                phase_end;
  logic                enter_low;

  // Oversized lengths are clamped so the bit counter never leaves the vector.
  assign len_sat   = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
  assign phase_end = (cnt_reg == CNT_LAST);
  assign enter_low = (state_next == S_LOW) && (state_reg != S_LOW);

`ifdef JTAG_SAMPLE_LATE_EN
  // Late capture: last clock of the high phase, giving slow targets a full half-period.
  assign sample_now = (state_reg == S_HIGH) && phase_end;
`else
  // Early capture: the clock edge that raises TCK sees TDO as set up during the low phase.
  assign sample_now = (state_reg == S_LOW) && phase_end;
`endif

  // Next-state logic: command latch, half-period counter, bit counter and TDO capture.
  always_comb begin
    state_next = state_reg;
    bit_next   = bit_reg;
    len_next   = len_reg;
    cnt_next   = cnt_reg;
    tms_next   = tms_reg;
    tdi_next   = tdi_reg;
    cap_next   = cap_reg;
    sel_next   = jtag_sel;

    if (sample_now) begin
      cap_next[bit_reg[IDX_W-1:0]] = v_tdo;
    end

    case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          len_next   = len_sat;
          tms_next   = bus.cmd_tms;
          tdi_next   = bus.cmd_tdi;
          sel_next   = bus.cmd_sel;
          bit_next   = 6'd0;
          cnt_next   = '0;
          cap_next   = '0;
          state_next = (len_sat == 6'd0) ? S_DONE : S_LOW;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          cnt_next   = '0;
          state_next = S_HIGH;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_next = '0;
          if (bit_reg == len_reg - 6'd1) begin
            state_next = S_DONE;
          end else begin
            bit_next   = bit_reg + 6'd1;
            state_next = S_LOW;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Internal state registers; reset abandons any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      bit_reg   <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      tms_reg   <= '0;
      tdi_reg   <= '0;
      cap_reg   <= '0;
    end else begin
      state_reg <= state_next;
      bit_reg   <= bit_next;
      len_reg   <= len_next;
      cnt_reg   <= cnt_next;
      tms_reg   <= tms_next;
      tdi_reg   <= tdi_next;
      cap_reg   <= cap_next;
    end
  end

  // Registered outputs decoded from the next state so pins change exactly on state edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_reg     <= 1'b1;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_tdo_reg   <= '0;
      jtag_sel      <= 4'hF;
      v_tck         <= 1'b0;
      v_tms         <= 1'b1;
      v_tdi         <= 1'b0;
    end else begin
      ready_reg     <= (state_next == S_IDLE);
      busy_reg      <= (state_next != S_IDLE);
      rsp_valid_reg <= (state_next == S_DONE);
      v_tck         <= (state_next == S_HIGH);
      jtag_sel      <= sel_next;
      if (state_next == S_DONE) begin
        rsp_tdo_reg <= cap_next;
      end
      // TMS/TDI only move when a low phase begins; they keep the last bit afterwards.
      if (enter_low) begin
        v_tms <= tms_next[bit_next[IDX_W-1:0]];
        v_tdi <= tdi_next[bit_next[IDX_W-1:0]];
      end
    end
  end

  assign bus.cmd_ready = ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_tdo   = rsp_tdo_reg;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Testbench for jtag_shift_engine: directed commands, scoreboard of expected responses,
// TCK/TMS/TDI pin monitors and a simple target model behind the mux.
`timescale 1ns/1ps
module tb_jtag_shift_engine;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [3:0] jtag_sel;
  logic       v_tck, v_tms, v_tdi, v_tdo;
  int         tdo_mode;   // 0: TDO=0, 1: TDO=1, 2: TDO loops back TDI

  jtag_shift_engine_if #(.MAX_BITS(32)) bus ();

  jtag_shift_engine #(.CLK_DIV(D), .MAX_BITS(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .jtag_sel (jtag_sel),
    .v_tck    (v_tck),
    .v_tms    (v_tms),
    .v_tdi    (v_tdi),
    .v_tdo    (v_tdo)
  );

  // Mux + target model: unselected (>=12) targets read back as 0.
  assign v_tdo = (jtag_sel >= 4'd12) ? 1'b0 :
                 (tdo_mode == 1) ? 1'b1 :
                 (tdo_mode == 2) ? v_tdi : 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin monitors: per-pulse TMS/TDI at TCK rise, high-phase length, stability, pulses of RSP_VALID.
  logic rise_tdi [0:4095];
  logic rise_tms [0:4095];
  logic last_tdi, last_tms;
  int   pulse_total = 0;
  int   high_total  = 0;
  int   glitch_total = 0;
  int   rsp_total   = 0;

  always @(posedge v_tck) begin
    rise_tdi[pulse_total % 4096] = v_tdi;
    rise_tms[pulse_total % 4096] = v_tms;
    last_tdi = v_tdi;
    last_tms = v_tms;
    pulse_total = pulse_total + 1;
  end

  always @(negedge clk) begin
    if (v_tck === 1'b1) begin
      high_total = high_total + 1;
      if (v_tdi !== last_tdi || v_tms !== last_tms) glitch_total = glitch_total + 1;
    end
    if (bus.rsp_valid === 1'b1) rsp_total = rsp_total + 1;
  end

  typedef struct {
    logic [31:0] tdo;
    logic [31:0] tdi;
    logic [31:0] tms;
    logic [3:0]  sel;
    int          lat;
    int          pulses;
    int          pulse_base;
    int          high_base;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one command, push its expected outcome, scramble inputs after accept.
  task automatic issue(input logic [3:0] sel, input logic [5:0] len,
                       input logic [31:0] tms, input logic [31:0] tdi,
                       input logic [31:0] tdo_exp);
    exp_t e;
    int   l;
    int   n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_issue", 32'(bus.cmd_ready), 32'd1);
    l = (int'(len) > 32) ? 32 : int'(len);
    e.tdo        = tdo_exp;
    e.tdi        = tdi;
    e.tms        = tms;
    e.sel        = sel;
    e.pulses     = l;
    e.lat        = 1 + 2 * D * l;
    e.pulse_base = pulse_total;
    e.high_base  = high_total;
    sb.push_back(e);
    bus.cmd_valid = 1'b1;
    bus.cmd_sel   = sel;
    bus.cmd_len   = len;
    bus.cmd_tms   = tms;
    bus.cmd_tdi   = tdi;
    @(posedge clk);
    #1;
    acc_cyc       = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = ~sel;
    bus.cmd_len   = 6'd63;
    bus.cmd_tms   = ~tms;
    bus.cmd_tdi   = ~tdi;
  endtask

  // Wait for the response, pop the scoreboard and compare everything about the command.
  task automatic wait_rsp(input string tag);
    exp_t        e;
    int          n;
    logic [31:0] mask;
    logic [31:0] obs_tdi;
    logic [31:0] obs_tms;
    n = 0;
    @(negedge clk);
    while (bus.rsp_valid !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_seen"}, 32'(bus.rsp_valid), 32'd1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      mask = (e.pulses >= 32) ? 32'hFFFF_FFFF : ((32'd1 << e.pulses) - 32'd1);
      obs_tdi = '0;
      obs_tms = '0;
      for (int i = 0; i < e.pulses; i++) begin
        obs_tdi[i] = rise_tdi[(e.pulse_base + i) % 4096];
        obs_tms[i] = rise_tms[(e.pulse_base + i) % 4096];
      end
      chk({tag, "_latency"}, 32'(cyc - acc_cyc + 1), 32'(e.lat));
      chk({tag, "_rsp_tdo"}, bus.rsp_tdo, e.tdo);
      chk({tag, "_jtag_sel"}, 32'(jtag_sel), 32'(e.sel));
      chk({tag, "_tck_pulses"}, 32'(pulse_total - e.pulse_base), 32'(e.pulses));
      chk({tag, "_tck_high_cycles"}, 32'(high_total - e.high_base), 32'(e.pulses * D));
      chk({tag, "_tdi_at_rise"}, obs_tdi, e.tdi & mask);
      chk({tag, "_tms_at_rise"}, obs_tms, e.tms & mask);
      chk({tag, "_tck_low_at_rsp"}, 32'(v_tck), 32'd0);
      chk({tag, "_busy_at_rsp"}, 32'(bus.busy), 32'd1);
    end
    @(negedge clk);
    chk({tag, "_rsp_one_cycle"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_ready_after_rsp"}, 32'(bus.cmd_ready), 32'd1);
    $display("txn %s: rsp_tdo=%h jtag_sel=%h pulses=%0d", tag, bus.rsp_tdo, jtag_sel, pulse_total - e.pulse_base);
  endtask

  initial begin
    int base;
    int n;
    int rsp_before;

    rst           = 1'b1;
    tdo_mode      = 0;
    bus.cmd_valid = 1'b0;
    bus.cmd_sel   = 4'd0;
    bus.cmd_len   = 6'd0;
    bus.cmd_tms   = '0;
    bus.cmd_tdi   = '0;
    last_tdi      = 1'b0;
    last_tms      = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_tdo", bus.rsp_tdo, 32'd0);
    chk("rst_jtag_sel", 32'(jtag_sel), 32'hF);
    chk("rst_tck", 32'(v_tck), 32'd0);
    chk("rst_tms", 32'(v_tms), 32'd1);
    chk("rst_tdi", 32'(v_tdi), 32'd0);
    $display("txn reset: ready=%b tck=%b tms=%b tdi=%b sel=%h", bus.cmd_ready, v_tck, v_tms, v_tdi, jtag_sel);

    // TMS all ones, TDO held high by target 3
    tdo_mode = 1;
    issue(4'd3, 6'd5, 32'h0000_001F, 32'h0, 32'h0000_001F);
    chk("t2_busy_after_accept", 32'(bus.busy), 32'd1);
    wait_rsp("t2_sel3_len5");

    // Full-width loopback
    tdo_mode = 2;
    issue(4'd1, 6'd32, 32'h8000_0001, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
    wait_rsp("t3_len32_loop");

    // Zero length, then oversized length (back to back)
    issue(4'd2, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    wait_rsp("t4_len0");
    issue(4'd2, 6'd40, 32'h0F0F_00FF, 32'h1234_5678, 32'h1234_5678);
    wait_rsp("t4_len40_sat");

    // Short command: bits above LEN must read as 0
    issue(4'd7, 6'd7, 32'h0000_0040, 32'hDEAD_BEDB, 32'h0000_005B);
    wait_rsp("t_len7_mask");

    // Reset in the middle of bit 10 of a 20-bit command
    base = pulse_total;
    issue(4'd5, 6'd20, 32'h000F_0F0F, 32'h0005_5AA5, 32'h0);
    n = 0;
    while (pulse_total < base + 11 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_bit10", 32'(pulse_total - base), 32'd11);
    chk("t5_tck_high_before_rst", 32'(v_tck), 32'd1);
    rsp_before = rsp_total;
    rst = 1'b1;
    #1;
    chk("t5_abort_tck", 32'(v_tck), 32'd0);
    chk("t5_abort_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t5_abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_abort_sel", 32'(jtag_sel), 32'hF);
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("t5_no_rsp_after_abort", 32'(rsp_total - rsp_before), 32'd0);
    $display("txn t5_abort: tck=%b ready=%b rsp_pulses=%0d", v_tck, bus.cmd_ready, rsp_total - rsp_before);
    issue(4'd3, 6'd5, 32'h0000_0003, 32'h0000_0016, 32'h0000_0016);
    wait_rsp("t5_after_abort");

    // Unselected target: normal pulses, TDO reads 0
    tdo_mode = 1;
    issue(4'd12, 6'd8, 32'h0000_0081, 32'h0000_00C3, 32'h0);
    wait_rsp("t6_sel12");

    chk("tdi_tms_stable_while_tck_high", 32'(glitch_total), 32'd0);
    chk("rsp_tdo_holds", bus.rsp_tdo, 32'h0);
    chk("jtag_sel_holds", 32'(jtag_sel), 32'd12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
